// File: rtl/program_counter.sv
// Fetch-stage program counter: a single registered address that resets,
// loads a jump target, or advances by one every clock.
module program_counter #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_addr_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Power-up value keeps simulation out of X; rst_i is still required in hardware.
  logic [ADDR_W-1:0] pc_q = RESET_ADDR;
  logic [ADDR_W-1:0] pc_d;

  // Reset beats jump, jump beats increment; the increment wraps naturally.
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (rst_i) begin
      pc_d = RESET_ADDR;
    end else if (jmp_en_i) begin
      pc_d = jmp_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q <= pc_d;
  end

  assign addr_o = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed scenarios followed by random
// reset/jump/count traffic, each edge checked against an arithmetic model.
module tb_program_counter;

  localparam int ADDR_W = 12;
  localparam int SPAN   = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              jmp_en;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] addr;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_pc    = 0;

  program_counter #(.ADDR_W(ADDR_W), .RESET_ADDR('0)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .jmp_en_i  (jmp_en),
    .jmp_addr_i(jmp_addr),
    .addr_o    (addr)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [ADDR_W-1:0] want;
    want = ADDR_W'(exp_pc);
    total_cnt++;
    assert (addr === want) pass_cnt++;
    else $error("FAIL %s: addr_o=0x%03h expected 0x%03h", tag, addr, want);
  endtask

  // One clock: drive on the falling edge, advance the model, check after the rising edge.
  task automatic step(input logic r, input logic j, input logic [ADDR_W-1:0] a,
                      input string tag);
    @(negedge clk);
    rst      = r;
    jmp_en   = j;
    jmp_addr = a;
    @(posedge clk);
    #1;
    if (r)      exp_pc = 0;
    else if (j) exp_pc = int'(a);
    else        exp_pc = (exp_pc + 1) % SPAN;
    check(tag);
  endtask

  initial begin
    rst      = 1'b0;
    jmp_en   = 1'b0;
    jmp_addr = '0;

    // Power-up value before any edge.
    #1;
    exp_pc = 0;
    check("powerup");

    // Reset held three cycles with jump idle.
    step(1'b1, 1'b0, 12'h000, "reset_0");
    step(1'b1, 1'b0, 12'h000, "reset_1");
    step(1'b1, 1'b0, 12'h000, "reset_2");

    // Count after release.
    step(1'b0, 1'b0, 12'h000, "inc_1");
    step(1'b0, 1'b0, 12'h000, "inc_2");
    step(1'b0, 1'b0, 12'h000, "inc_3");

    // Jump held two cycles, then count from target.
    step(1'b0, 1'b1, 12'h0F0, "jmp_0");
    step(1'b0, 1'b1, 12'h0F0, "jmp_hold");
    step(1'b0, 1'b0, 12'h0F0, "jmp_inc_1");
    step(1'b0, 1'b0, 12'h0F0, "jmp_inc_2");

    // Target changing with jump disabled must be ignored.
    step(1'b0, 1'b0, 12'hABC, "idle_addr_1");
    step(1'b0, 1'b0, 12'h123, "idle_addr_2");

    // Reset overrides a simultaneous jump.
    step(1'b1, 1'b1, 12'h0F0, "rst_over_jmp");
    step(1'b0, 1'b0, 12'h0F0, "rst_release");

    // Wrap-around at the top of the address space.
    step(1'b0, 1'b1, 12'hFFE, "wrap_ffe");
    step(1'b0, 1'b0, 12'h000, "wrap_fff");
    step(1'b0, 1'b0, 12'h000, "wrap_000");
    step(1'b0, 1'b0, 12'h000, "wrap_001");

    // Count to 0x005, then a one-cycle reset pulse.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000, "mid_count");
    step(1'b1, 1'b0, 12'h000, "mid_rst");
    step(1'b0, 1'b0, 12'h000, "mid_rst_inc");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic j;
      logic [ADDR_W-1:0] a;
      r = ($urandom_range(0, 19) == 0);
      j = ($urandom_range(0, 4) == 0);
      a = ADDR_W'($urandom_range(0, SPAN - 1));
      if ($urandom_range(0, 9) == 0) a = 12'hFFF;
      step(r, j, a, "random");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
